// File: rtl/taglist_player_if.sv
// Control, taglist-RAM and pattern-ROM signals of the taglist player.
// The master side drives requests and RAM data; the slave is the player.
interface taglist_player_if;
    logic        start;
    logic [6:0]  seq_sel;
    logic        loop;
    logic        stop;
    logic        tl_rd;
    logic [6:0]  tl_addr;
    logic [31:0] tl_data;
    logic [9:0]  rom_addr;
    logic        rom_en;
    logic        busy;
    logic        done;
    logic        err;
    logic        end_flag;

    modport master (
        output start, seq_sel, loop, stop, tl_data,
        input  tl_rd, tl_addr, rom_addr, rom_en,
        input  busy, done, err, end_flag
    );

    modport slave (
        input  start, seq_sel, loop, stop, tl_data,
        output tl_rd, tl_addr, rom_addr, rom_en,
        output busy, done, err, end_flag
    );
endinterface

// File: rtl/taglist_player.sv
// Fetches one taglist entry, validates it, then walks the pattern ROM
// from first to last address, holding each address HOLD_CYCLES cycles.
module taglist_player #(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input logic             clk_1KHz,
    input logic             reset,
    taglist_player_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        PLAY
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t      state_q;
    logic [6:0]  seq_q;
    logic        loop_q;
    logic [9:0]  first_q;
    logic [9:0]  last_q;
    logic [7:0]  hold_q;
    logic        tl_rd_q;
    logic [6:0]  tl_addr_q;
    logic [9:0]  rom_addr_q;
    logic        rom_en_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        end_flag_q;

    logic [9:0]  e_first;
    logic [9:0]  e_last;
    logic        entry_ok;

    assign e_first  = bus.tl_data[20:11];
    assign e_last   = bus.tl_data[10:1];
    assign entry_ok = (bus.tl_data[31:28] == 4'd0)
                   && (bus.tl_data[27:21] == seq_q)
                   && (e_first <= e_last);

    always_ff @(posedge clk_1KHz) begin
        if (reset) begin
            state_q    <= IDLE;
            seq_q      <= '0;
            loop_q     <= 1'b0;
            first_q    <= '0;
            last_q     <= '0;
            hold_q     <= '0;
            tl_rd_q    <= 1'b0;
            tl_addr_q  <= '0;
            rom_addr_q <= '0;
            rom_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            end_flag_q <= 1'b0;
        end else begin
            tl_rd_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        seq_q     <= bus.seq_sel;
                        loop_q    <= bus.loop;
                        tl_addr_q <= bus.seq_sel;
                        tl_rd_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.stop) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.stop) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (entry_ok) begin
                        first_q    <= e_first;
                        last_q     <= e_last;
                        rom_addr_q <= e_first;
                        rom_en_q   <= 1'b1;
                        end_flag_q <= bus.tl_data[0];
                        hold_q     <= '0;
                        state_q    <= PLAY;
                    end else begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                PLAY: begin
                    if (bus.stop) begin
                        rom_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else if (hold_q == HOLD_LAST) begin
                        hold_q <= '0;
                        // Equality test, not increment, ends a run at 1023.
                        if (rom_addr_q != last_q) begin
                            rom_addr_q <= rom_addr_q + 10'd1;
                        end else if (loop_q) begin
                            rom_addr_q <= first_q;
                        end else begin
                            rom_en_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= IDLE;
                        end
                    end else begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.tl_rd    = tl_rd_q;
    assign bus.tl_addr  = tl_addr_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rom_en   = rom_en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.end_flag = end_flag_q;
endmodule

// File: tb/tb_taglist_player.sv
// Bench for taglist_player: HOLD_CYCLES=1 and =2 instances share stimulus
// and are compared each cycle against a per-entry playback model.
module tb_taglist_player;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  seq_sel;
    logic        loop_r;
    logic        stop;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] mem [128];

    int n_checks = 0;
    int n_err    = 0;

    logic [9:0] la [2];
    logic [6:0] ta [2];
    logic       ef [2];

    always #5 clk = ~clk;

    taglist_player_if if1 ();
    taglist_player_if if2 ();

    assign if1.start   = start;
    assign if1.seq_sel = seq_sel;
    assign if1.loop    = loop_r;
    assign if1.stop    = stop;
    assign if1.tl_data = d1;
    assign if2.start   = start;
    assign if2.seq_sel = seq_sel;
    assign if2.loop    = loop_r;
    assign if2.stop    = stop;
    assign if2.tl_data = d2;

    taglist_player #(.HOLD_CYCLES(1)) u_dut1 (
        .clk_1KHz (clk),
        .reset    (reset),
        .bus      (if1)
    );

    taglist_player #(.HOLD_CYCLES(2)) u_dut2 (
        .clk_1KHz (clk),
        .reset    (reset),
        .bus      (if2)
    );

    // Taglist RAM: one-cycle read latency per instance.
    always @(posedge clk) begin
        if (if1.tl_rd) d1 <= mem[if1.tl_addr];
        if (if2.tl_rd) d2 <= mem[if2.tl_addr];
    end

    logic [22:0] obs0;
    logic [22:0] obs1;
    assign obs0 = {if1.tl_rd, if1.tl_addr, if1.rom_addr, if1.rom_en,
                   if1.busy, if1.done, if1.err, if1.end_flag};
    assign obs1 = {if2.tl_rd, if2.tl_addr, if2.rom_addr, if2.rom_en,
                   if2.busy, if2.done, if2.err, if2.end_flag};

    function automatic logic [31:0] mk(input logic [3:0] r,
                                       input logic [6:0] s,
                                       input logic [9:0] f,
                                       input logic [9:0] l,
                                       input logic fl);
        return {r, s, f, l, fl};
    endfunction

    task automatic chk(input string tag, input int n, input int i,
                       input logic [22:0] exp_v);
        logic [22:0] got;
        got = (i == 0) ? obs0 : obs1;
        n_checks++;
        assert (got === exp_v) else begin
            n_err++;
            $error("FAIL %s inst%0d n=%0d got=%h exp=%h",
                   tag, i, n, got, exp_v);
        end
    endtask

    function automatic logic [22:0] idle_vec(input int i);
        return {1'b0, ta[i], la[i], 4'b0000, ef[i]};
    endfunction

    // One start request; n counts edges since the start edge.
    task automatic scn(input string tag, input logic [6:0] sq,
                       input logic [31:0] ent, input logic lp,
                       input int stop_e, input int rst_e,
                       input int noise_e, input int ncyc);
        int  fst;
        int  lst;
        bit  ok;
        mem[sq] = ent;
        fst = int'(ent[20:11]);
        lst = int'(ent[10:1]);
        ok  = (ent[31:28] == 4'd0) && (ent[27:21] == sq) && (fst <= lst);
        @(negedge clk);
        start = 1'b1; seq_sel = sq; loop_r = lp; stop = 1'b0;
        for (int n = 0; n <= ncyc; n++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                logic tr, en, bs, dn, er;
                int p, ln;
                tr = 0; en = 0; bs = 0; dn = 0; er = 0;
                if (rst_e != 0 && n >= rst_e) begin
                    la[i] = '0; ta[i] = '0; ef[i] = 1'b0;
                end else if (n == 0) begin
                    tr = 1; bs = 1; ta[i] = sq;
                end else if (stop_e != 0 && n >= stop_e) begin
                    bs = 0;
                end else if (n == 1) begin
                    bs = 1;
                end else if (!ok) begin
                    er = (n == 2);
                end else begin
                    if (n == 2) ef[i] = ent[0];
                    p  = n - 2;
                    ln = (lst - fst + 1) * (i + 1);
                    if (!lp && p >= ln) begin
                        dn = (p == ln);
                    end else begin
                        en = 1; bs = 1;
                        la[i] = 10'(fst + (p % ln) / (i + 1));
                    end
                end
                chk(tag, n, i, {tr, ta[i], la[i], en, bs, dn, er, ef[i]});
            end
            @(negedge clk);
            start = (n + 1 == noise_e);
            stop  = (n + 1 == stop_e);
            reset = (n + 1 == rst_e);
        end
        start = 1'b0; reset = 1'b0; stop = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic idle_ss(input string tag);
        @(negedge clk);
        start = 1'b1; stop = 1'b1; seq_sel = 7'd5;
        @(posedge clk);
        #1;
        chk(tag, 0, 0, idle_vec(0));
        chk(tag, 0, 1, idle_vec(1));
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int sq, f, l, c, se;
        logic [31:0] ent;
        logic lp;
        for (int a = 0; a < 128; a++) mem[a] = '0;
        for (int i = 0; i < 2; i++) begin
            la[i] = '0; ta[i] = '0; ef[i] = 1'b0;
        end
        d1 = '0; d2 = '0;
        reset = 1'b1; start = 1'b1; seq_sel = 7'd5;
        loop_r = 1'b0; stop = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("reset", k, 0, 23'd0);
            chk("reset", k, 1, 23'd0);
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b0;

        scn("basic", 7'd5, mk(4'd0, 7'd5, 10'd10, 10'd12, 1'b1),
            1'b0, 0, 0, 0, 12);
        idle_ss("start_stop_idle");
        scn("bad_seq", 7'd6, mk(4'd0, 7'd7, 10'd1, 10'd2, 1'b0),
            1'b0, 0, 0, 0, 5);
        scn("bad_order", 7'd9, mk(4'd0, 7'd9, 10'd20, 10'd15, 1'b0),
            1'b0, 0, 0, 0, 5);
        scn("bad_rsv", 7'd10, mk(4'h8, 7'd10, 10'd1, 10'd1, 1'b0),
            1'b0, 0, 0, 0, 5);
        scn("loop", 7'd3, mk(4'd0, 7'd3, 10'd3, 10'd4, 1'b0),
            1'b1, 6, 0, 4, 9);
        scn("single", 7'd12, mk(4'd0, 7'd12, 10'd500, 10'd500, 1'b1),
            1'b0, 0, 0, 0, 8);
        scn("top", 7'd13, mk(4'd0, 7'd13, 10'd1021, 10'd1023, 1'b0),
            1'b0, 0, 0, 0, 12);
        scn("top_loop", 7'd14, mk(4'd0, 7'd14, 10'd1022, 10'd1023, 1'b1),
            1'b1, 11, 0, 0, 12);
        scn("rst_play", 7'd5, mk(4'd0, 7'd5, 10'd10, 10'd12, 1'b1),
            1'b0, 0, 4, 0, 6);
        scn("after_rst", 7'd5, mk(4'd0, 7'd5, 10'd10, 10'd12, 1'b0),
            1'b0, 0, 0, 0, 10);
        scn("stop_fetch", 7'd20, mk(4'd0, 7'd20, 10'd7, 10'd9, 1'b1),
            1'b0, 1, 0, 0, 5);
        scn("stop_wait", 7'd21, mk(4'd0, 7'd22, 10'd7, 10'd9, 1'b1),
            1'b0, 2, 0, 0, 5);

        for (int r = 0; r < 25; r++) begin
            sq = $urandom_range(0, 127);
            f  = $urandom_range(0, 1023);
            l  = f + $urandom_range(0, 5);
            if (l > 1023) l = 1023;
            ent = mk(4'd0, 7'(sq), 10'(f), 10'(l), 1'($urandom_range(0, 1)));
            c = $urandom_range(0, 7);
            if (c == 0) ent[31:28] = 4'($urandom_range(1, 15));
            if (c == 1) ent[27:21] = 7'(sq + 1);
            if (c == 2) begin
                ent[20:11] = (l < 1023) ? 10'(l + 1) : 10'd1023;
                ent[10:1]  = (l < 1023) ? 10'(l) : 10'd0;
            end
            lp = 1'($urandom_range(0, 2) == 0);
            if (lp) se = $urandom_range(1, 15);
            else if ($urandom_range(0, 3) == 0) se = $urandom_range(1, 15);
            else se = 0;
            scn("random", 7'(sq), ent, lp, se, 0, 0, 17);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/taglist_player.md
TAGLIST_PLAYER -- requirements
Module: taglist_player

Interface
REQ-001 Parameter HOLD_CYCLES, default 1, number of clk_1KHz cycles each ROM address is held; legal range 1..255.
REQ-002 clk_1KHz  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  playback request, sampled only in IDLE.
REQ-005 seq_sel  input  7  sequence number to play, sampled with start.
REQ-006 loop  input  1  repeat mode, sampled with start.
REQ-007 stop  input  1  abort request, honoured in any non-IDLE state.
REQ-008 tl_rd  output  1  taglist RAM read strobe, one cycle wide.
REQ-009 tl_addr  output  7  taglist RAM read address.
REQ-010 tl_data  input  32  taglist entry, valid the cycle after tl_rd.
REQ-011 rom_addr  output  10  pattern ROM address being played.
REQ-012 rom_en  output  1  high while rom_addr is valid playback.
REQ-013 busy  output  1  high in every non-IDLE state.
REQ-014 done  output  1  one-cycle pulse on normal completion.
REQ-015 err  output  1  one-cycle pulse on a rejected entry.
REQ-016 end_flag  output  1  bit 0 of the last accepted entry; held until the next accepted entry.

Function
REQ-017 Entry format: [31:28] reserved zero, [27:21] sequence number, [20:11] first address, [10:1] last address, [0] end-of-ROM flag.
REQ-018 States: IDLE, FETCH, WAIT, PLAY; no other reachable states.
REQ-019 IDLE with start=1, stop=0 at edge k: latch seq_sel and loop; tl_addr=seq_sel; tl_rd=1; busy=1; enter FETCH.
REQ-020 FETCH at edge k+1: tl_rd=0; enter WAIT.
REQ-021 WAIT at edge k+2: sample tl_data and validate: [31:28]==0, [27:21]==latched seq, first<=last.
REQ-022 Validation pass: rom_addr=first; rom_en=1; end_flag=tl_data[0]; hold counter cleared; enter PLAY.
REQ-023 Validation fail: err=1 for one cycle; busy=0; rom_en never asserted; enter IDLE.
REQ-024 PLAY: each address is held exactly HOLD_CYCLES cycles; then rom_addr increments by 1.
REQ-025 Last address completes its hold with loop latched 0: rom_en=0, busy=0, done=1 for one cycle; enter IDLE.
REQ-026 Last address completes its hold with loop latched 1: rom_addr=first; playback continues without gap; done is not pulsed.
REQ-027 first==last: one address is played for HOLD_CYCLES cycles.
REQ-028 last==1023: playback terminates on equality; rom_addr never wraps to 0.
REQ-029 Address comparison and increment are 10-bit unsigned; the hold counter is 8-bit.
REQ-030 stop=1 in FETCH, WAIT or PLAY: at the next edge rom_en=0, busy=0, done=0, err=0, tl_rd=0; enter IDLE.
REQ-031 stop has priority over completion, validation and looping in the same cycle.
REQ-032 start in a non-IDLE state is ignored and is not queued.
REQ-033 start and stop both high in IDLE: remain IDLE; no outputs change.
REQ-034 done and err are never high in the same cycle.
REQ-035 tl_addr holds its last value outside FETCH.
REQ-036 rom_addr holds its last value when rom_en=0.

Reset
REQ-037 reset=1 at an edge: state=IDLE; tl_rd, rom_en, busy, done, err, end_flag=0; tl_addr=0; rom_addr=0; hold counter=0; latched seq and loop=0.
REQ-038 reset overrides start, stop and every in-progress state, including mid-PLAY; no done or err pulse results.

Verification
REQ-039 Reset for 2 cycles with start=1 -> all outputs 0, state IDLE, no tl_rd.
REQ-040 Entry 5 = {0, seq 5, first 10, last 12, flag 1}; HOLD_CYCLES=1; start with seq_sel=5 at edge k -> tl_rd at k; rom_addr 10, 11, 12 at edges k+2..k+4; done at k+5; end_flag=1.
REQ-041 Entry 6 holding seq 7 -> err at k+2; rom_en stays 0. Entry with first=20, last=15 -> err at k+2.
REQ-042 loop=1, first=3, last=4, HOLD_CYCLES=2 -> rom_addr 3,3,4,4,3,3,...; stop on the second cycle of 4 -> rom_en=0, busy=0 at the next edge; no done.
REQ-043 start pulsed during PLAY -> no second tl_rd; start and stop high together in IDLE -> no tl_rd.
REQ-044 reset asserted during PLAY at rom_addr 11 -> all outputs 0 at the next edge; start one cycle later -> fresh tl_rd.
